dl_shift_unit: RTL and testbench
================================

DL_SHIFT_UNIT -- requirements
Module: dl_shift_unit

Interface
REQ-001 The block SHALL have parameter NUM_BITS, default 32: operand/result width; legal values are powers of two >= 4.
REQ-002 The block SHALL have parameter NUM_SHIFT_BITS, default $clog2(NUM_BITS): shift-amount width, derived and never overridden.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: upstream offers an operation.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts the operation this cycle.
REQ-007 The block SHALL have port in_op, input, 3 bits: shift_op_t operation code.
REQ-008 The block SHALL have port in_data, input, NUM_BITS: operand to shift.
REQ-009 The block SHALL have port in_shamt, input, NUM_SHIFT_BITS: shift amount.
REQ-010 The block SHALL have port out_valid, output, 1 bit: result available.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream takes the result.
REQ-012 The block SHALL have port out_data, output, NUM_BITS: shifted result.

Function
REQ-013 The block SHALL decode ops as: SLL=0, SRL=1, SRA=2, ROL=3, ROR=4; codes 5-7 SHALL produce result 0.
REQ-014 The block SHALL be a two-stage pipeline:
- Stage 1 registers op, data and shamt on an accepted input.
- Stage 2 registers the computed result.
- Latency is exactly 2 cycles from acceptance to out_valid when unstalled.
REQ-015 A transfer SHALL occur on a port exactly when valid and ready are both high on a rising edge.
REQ-016 Stage 1 SHALL advance when it holds data and stage 2 is empty or out_ready=1.
REQ-017 in_ready SHALL equal (stage 1 empty) OR (stage 1 advancing); this is combinational and gives full throughput of one op per cycle.
REQ-018 With out_valid=1 and out_ready=0, out_data and out_valid SHALL hold stable, and the stage-1 contents SHALL hold.
REQ-019 SRL SHALL be computed by bit-reversing the operand, left-shifting, and reversing again; SRA SHALL additionally fill vacated MSBs with in_data[NUM_BITS-1].
REQ-020 Shamt=0 SHALL return the operand unchanged for every legal op.
REQ-021 Rotates SHALL wrap modulo NUM_BITS with no bit lost.
REQ-022 Simultaneous output and input transfers in one cycle SHALL both complete, with no bubble and no duplication.

Reset
REQ-023 While rst=1 at a clock edge, both stage valid flags SHALL clear, so out_valid=0 and in_ready=1 in the following cycle.
REQ-024 Data registers SHALL reset to 0, so out_data=0 after reset.
REQ-025 Reset asserted mid-operation SHALL discard in-flight ops, which SHALL never appear on the output.
REQ-026 An input offered in a cycle where rst=1 SHALL NOT be accepted.

Configuration
REQ-027 The macro DL_SHIFT_ROT_EN SHALL control rotate support:
- Defined: ROL and ROR behave per REQ-021.
- Undefined: ROL executes as SLL, ROR executes as SRL, and the rotate datapath is not synthesized.

Structure
REQ-028 Package dl_shift_pkg SHALL hold the shift_op_t enum (3 bits) and the op-code localparams.
REQ-029 The left-shift core SHALL be instantiated as sub-module dl_lshift (ports in, shamt, out); all shift directions SHALL reuse this one instance.

Verification
REQ-030 The bench SHALL use NUM_BITS=8 and cover at least these scenarios:
- SLL, data 0x81, shamt 1, out_ready=1 -> out_data 0x02, out_valid exactly 2 cycles after acceptance.
- SRL 0x80 shamt 3 -> 0x10; SRA 0x80 shamt 3 -> 0xF0; SRA 0x7F shamt 7 -> 0x00; any op with shamt 0 -> operand unchanged.
- ROR 0x01 shamt 1 -> 0x80 and ROL 0x81 shamt 4 -> 0x18 with DL_SHIFT_ROT_EN; without it, ROR 0x01 shamt 1 -> 0x00 and ROL 0x81 shamt 4 -> 0x10.
- Back-to-back ops, out_ready=0 for 3 cycles:
  - out_data stays stable;
  - in_ready drops after two ops are held;
  - on release, results emerge in order with no loss.
- Continuous valid/ready both high for 16 random ops -> one result per cycle, matching the reference model.
- rst pulsed while both stages are full -> out_valid=0 and in_ready=1 the next cycle, and no stale result is emitted afterward.

Source files
------------

// File: rtl/dl_shift_pkg.sv
// Shared op-code definitions for the dl_shift_unit shifter pipeline.
package dl_shift_pkg;

    localparam logic [2:0] OPC_SLL = 3'd0;
    localparam logic [2:0] OPC_SRL = 3'd1;
    localparam logic [2:0] OPC_SRA = 3'd2;
    localparam logic [2:0] OPC_ROL = 3'd3;
    localparam logic [2:0] OPC_ROR = 3'd4;

    typedef enum logic [2:0] {
        SHIFT_SLL = OPC_SLL,
        SHIFT_SRL = OPC_SRL,
        SHIFT_SRA = OPC_SRA,
        SHIFT_ROL = OPC_ROL,
        SHIFT_ROR = OPC_ROR
    } shift_op_t;

endpackage

// File: rtl/dl_shift_unit_lshift.sv
// Funnel left-shift core: returns the top NUM_BITS of {in} shifted left by shamt,
// so the low half of in supplies the bits shifted into the vacated LSBs.
module dl_lshift #(
    parameter int NUM_BITS       = 32,
    parameter int NUM_SHIFT_BITS = $clog2(NUM_BITS)
) (
    input  logic [2*NUM_BITS-2:0]     in,
    input  logic [NUM_SHIFT_BITS-1:0] shamt,
    output logic [NUM_BITS-1:0]       out
);

    logic [NUM_SHIFT_BITS:0] base;

    // The low fill half is one bit short of NUM_BITS: shamt never exceeds NUM_BITS-1.
    assign base = {1'b0, NUM_SHIFT_BITS'(NUM_BITS - 1)} - {1'b0, shamt};
    assign out  = in[base +: NUM_BITS];

endmodule

// File: rtl/dl_shift_unit.sv
// Two-stage valid/ready shift pipeline (SLL/SRL/SRA/ROL/ROR) built on one left-shift core.
// Rotates are enabled by defining DL_SHIFT_ROT_EN; otherwise ROL acts as SLL and ROR as SRL.
module dl_shift_unit
    import dl_shift_pkg::*;
#(
    parameter int NUM_BITS       = 32,
    parameter int NUM_SHIFT_BITS = $clog2(NUM_BITS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2:0]                in_op,
    input  logic [NUM_BITS-1:0]       in_data,
    input  logic [NUM_SHIFT_BITS-1:0] in_shamt,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_BITS-1:0]       out_data
);

    logic                      s1_valid_reg;
    shift_op_t                 s1_op_reg;
    logic [NUM_BITS-1:0]       s1_data_reg;
    logic [NUM_SHIFT_BITS-1:0] s1_shamt_reg;
    logic                      s2_valid_reg;
    logic [NUM_BITS-1:0]       s2_data_reg;

    logic                      s1_advance;
    logic                      accept;
    logic [NUM_BITS-1:0]       data_rev;
    logic [NUM_BITS-1:0]       shift_out;
    logic [NUM_BITS-1:0]       shift_rev;
    logic [2*NUM_BITS-2:0]     shift_in;
    logic                      use_rev;
    logic                      op_legal;
    logic [NUM_BITS-1:0]       result_next;
    logic                      sign_bit;

    assign s1_advance = s1_valid_reg && (!s2_valid_reg || out_ready);
    assign in_ready   = !s1_valid_reg || s1_advance;
    assign accept     = in_valid && in_ready;
    assign sign_bit   = s1_data_reg[NUM_BITS-1];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BITS; gi++) begin : g_rev
            assign data_rev[gi]  = s1_data_reg[NUM_BITS-1-gi];
            assign shift_rev[gi] = shift_out[NUM_BITS-1-gi];
        end
    endgenerate

    // Right-going ops run the reversed operand through the same left shifter.
    always_comb begin
        shift_in = {s1_data_reg, {(NUM_BITS-1){1'b0}}};
        use_rev  = 1'b0;
        op_legal = 1'b1;
        case (s1_op_reg)
            SHIFT_SLL: shift_in = {s1_data_reg, {(NUM_BITS-1){1'b0}}};
            SHIFT_SRL: begin
                shift_in = {data_rev, {(NUM_BITS-1){1'b0}}};
                use_rev  = 1'b1;
            end
            SHIFT_SRA: begin
                shift_in = {data_rev, {(NUM_BITS-1){sign_bit}}};
                use_rev  = 1'b1;
            end
`ifdef DL_SHIFT_ROT_EN
            SHIFT_ROL: shift_in = {s1_data_reg, s1_data_reg[NUM_BITS-1:1]};
            SHIFT_ROR: begin
                shift_in = {data_rev, data_rev[NUM_BITS-1:1]};
                use_rev  = 1'b1;
            end
`else
            SHIFT_ROL: shift_in = {s1_data_reg, {(NUM_BITS-1){1'b0}}};
            SHIFT_ROR: begin
                shift_in = {data_rev, {(NUM_BITS-1){1'b0}}};
                use_rev  = 1'b1;
            end
`endif
            default: op_legal = 1'b0;
        endcase
    end

    dl_lshift #(
        .NUM_BITS      (NUM_BITS),
        .NUM_SHIFT_BITS(NUM_SHIFT_BITS)
    ) u_lshift (
        .in   (shift_in),
        .shamt(s1_shamt_reg),
        .out  (shift_out)
    );

    assign result_next = !op_legal ? '0 : (use_rev ? shift_rev : shift_out);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_op_reg    <= SHIFT_SLL;
            s1_data_reg  <= '0;
            s1_shamt_reg <= '0;
            s2_valid_reg <= 1'b0;
            s2_data_reg  <= '0;
        end else begin
            if (accept) begin
                s1_valid_reg <= 1'b1;
                s1_op_reg    <= shift_op_t'(in_op);
                s1_data_reg  <= in_data;
                s1_shamt_reg <= in_shamt;
            end else if (s1_advance) begin
                s1_valid_reg <= 1'b0;
            end
            if (s1_advance) begin
                s2_valid_reg <= 1'b1;
                s2_data_reg  <= result_next;
            end else if (out_ready) begin
                s2_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid = s2_valid_reg;
    assign out_data  = s2_data_reg;

endmodule

// File: tb/tb_dl_shift_unit.sv
// Directed and short random checks of dl_shift_unit at NUM_BITS=8 (honours DL_SHIFT_ROT_EN).
module tb_dl_shift_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_op;
    logic [7:0] in_data;
    logic [2:0] in_shamt;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;

    int errors = 0;
    int checks = 0;
    int pops   = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    dl_shift_unit #(.NUM_BITS(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_data  (in_data),
        .in_shamt (in_shamt),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    function automatic logic [7:0] ref_shift(input logic [2:0] op, input logic [7:0] d, input logic [2:0] s);
        logic signed [7:0] sd;
        logic [3:0] inv;
        sd  = d;
        inv = 4'd8 - {1'b0, s};
        case (op)
            3'd0: return d << s;
            3'd1: return d >> s;
            3'd2: return 8'(sd >>> s);
`ifdef DL_SHIFT_ROT_EN
            3'd3: return (d << s) | (d >> inv);
            3'd4: return (d >> s) | (d << inv);
`else
            3'd3: return d << s;
            3'd4: return d >> s;
`endif
            default: return 8'h00;
        endcase
    endfunction

    // Called at a falling edge after inputs are set: records the handshakes of the coming edge.
    task automatic step();
        #1;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_spurious", 32'(out_valid), 32'd0);
                end else begin
                    check("sb_order", 32'(out_data), 32'(exp_q.pop_front()));
                    pops++;
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(ref_shift(in_op, in_data, in_shamt));
        end
        @(negedge clk);
    endtask

    task automatic single(input string tag, input logic [2:0] op, input logic [7:0] d,
                          input logic [2:0] s, input logic [7:0] exp);
        in_valid  = 1'b1;
        in_op     = op;
        in_data   = d;
        in_shamt  = s;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check({tag, "_lat1"}, 32'(out_valid), 32'd0);
        step();
        check({tag, "_lat2"}, 32'(out_valid), 32'd1);
        check(tag, 32'(out_data), 32'(exp));
        step();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = 3'd0;
        in_data   = 8'h00;
        in_shamt  = 3'd0;
        out_ready = 1'b0;
        @(negedge clk);
        step();
        step();
        rst = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_data", 32'(out_data), 32'd0);

        single("sll_81_1", 3'd0, 8'h81, 3'd1, 8'h02);
        single("srl_80_3", 3'd1, 8'h80, 3'd3, 8'h10);
        single("sra_80_3", 3'd2, 8'h80, 3'd3, 8'hF0);
        single("sra_7f_7", 3'd2, 8'h7F, 3'd7, 8'h00);
        single("srl_80_7", 3'd1, 8'h80, 3'd7, 8'h01);
        single("sll_01_7", 3'd0, 8'h01, 3'd7, 8'h80);
        single("sra_90_1", 3'd2, 8'h90, 3'd1, 8'hC8);
        for (int i = 0; i < 5; i++)
            single($sformatf("op%0d_shamt0", i), 3'(i), 8'hA5, 3'd0, 8'hA5);
        for (int i = 5; i < 8; i++)
            single($sformatf("op%0d_illegal", i), 3'(i), 8'hFF, 3'd2, 8'h00);
`ifdef DL_SHIFT_ROT_EN
        single("ror_01_1", 3'd4, 8'h01, 3'd1, 8'h80);
        single("rol_81_4", 3'd3, 8'h81, 3'd4, 8'h18);
        single("rol_81_7", 3'd3, 8'h81, 3'd7, 8'hC0);
`else
        single("ror_01_1", 3'd4, 8'h01, 3'd1, 8'h00);
        single("rol_81_4", 3'd3, 8'h81, 3'd4, 8'h10);
        single("rol_81_7", 3'd3, 8'h81, 3'd7, 8'h80);
`endif

        // Stall: two ops fill the pipe, a third waits while out_ready is low.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op = 3'd0; in_data = 8'h03; in_shamt = 3'd2;
        step();
        check("stall_in_ready_1", 32'(in_ready), 32'd1);
        in_op = 3'd1; in_data = 8'hF0; in_shamt = 3'd4;
        step();
        in_op = 3'd2; in_data = 8'h90; in_shamt = 3'd1;
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", 32'(out_data), 32'h0C);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        check("release_b", 32'(out_data), 32'h0F);
        in_valid = 1'b0;
        step();
        check("release_c", 32'(out_data), 32'hC8);
        step();
        check("release_empty", 32'(out_valid), 32'd0);

        // Full-throughput random burst.
        pops = 0;
        for (int i = 0; i < 16; i++) begin
            in_valid  = 1'b1;
            out_ready = 1'b1;
            in_op     = 3'($urandom_range(0, 4));
            in_data   = 8'($urandom);
            in_shamt  = 3'($urandom);
            check("burst_in_ready", 32'(in_ready), 32'd1);
            if (i >= 2)
                check("burst_out_valid", 32'(out_valid), 32'd1);
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        check("burst_count", 32'(pops), 32'd16);

        // Reset with both stages full; an op offered during reset must be dropped.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op = 3'd0; in_data = 8'h11; in_shamt = 3'd1;
        step();
        in_data = 8'h22;
        step();
        check("prerst_full", 32'(in_ready), 32'd0);
        rst       = 1'b1;
        out_ready = 1'b1;
        in_data   = 8'h33;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_data", 32'(out_data), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("postrst_no_stale", 32'(out_valid), 32'd0);
        end
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
